// File: rtl/alu_pkg.sv
// Shared constants and helpers for the RV32 ALU operand decoder:
// opcode, funct3 and funct7 encodings, register index width, and opcode classification.
package alu_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    CLS_R       = 2'd0,
    CLS_I       = 2'd1,
    CLS_ILLEGAL = 2'd2
  } op_class_e;

  function automatic op_class_e classify(input logic [6:0] opcode);
    op_class_e cls;
    case (opcode)
      OP_R:    cls = CLS_R;
      OP_I:    cls = CLS_I;
      default: cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_decode_if.sv
// Handshake, write-back and decoded-field bundle between the instruction source,
// the decoder (slave) and its consumer; the master side drives instructions and write-backs.
interface alu_decode_if #(parameter int WIDTH = 32);

  logic [31:0]              iInstr;
  logic                     iInstrValid;
  logic                     oInstrReady;
  logic                     iWbEn;
  logic [4:0]               iWbAddr;
  logic [WIDTH-1:0]         iWbData;
  logic signed [WIDTH-1:0]  oRS1;
  logic signed [WIDTH-1:0]  oRS2;
  logic [11:0]              oImm;
  logic [4:0]               oShamt;
  logic [4:0]               oRdAddr;
  logic [6:0]               oOpcode;
  logic [2:0]               oFunct3;
  logic [6:0]               oFunct7;
  logic                     oValid;
  logic                     iReady;
  logic                     oIllegal;

  modport slave (
    input  iInstr, iInstrValid, iWbEn, iWbAddr, iWbData, iReady,
    output oInstrReady, oRS1, oRS2, oImm, oShamt, oRdAddr,
           oOpcode, oFunct3, oFunct7, oValid, oIllegal
  );

  modport master (
    output iInstr, iInstrValid, iWbEn, iWbAddr, iWbData, iReady,
    input  oInstrReady, oRS1, oRS2, oImm, oShamt, oRdAddr,
           oOpcode, oFunct3, oFunct7, oValid, oIllegal
  );

endinterface

// File: rtl/alu_regfile.sv
// 32-entry register file: two asynchronous read ports, one synchronous write port.
// Index 0 reads as zero and ignores writes.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 iClk,
  input  logic                 iRstN,
  input  logic                 iWe,
  input  logic [REG_IDX_W-1:0] iWAddr,
  input  logic [WIDTH-1:0]     iWData,
  input  logic [REG_IDX_W-1:0] iRAddr1,
  input  logic [REG_IDX_W-1:0] iRAddr2,
  output logic [WIDTH-1:0]     oRData1,
  output logic [WIDTH-1:0]     oRData2
);

  logic [WIDTH-1:0] r_regs [NUM_REGS];
  logic             w_wr_ok;

  assign w_wr_ok = iWe && (iWAddr != {REG_IDX_W{1'b0}});

  // Register storage with asynchronous clear
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= {WIDTH{1'b0}};
      end
    end else if (w_wr_ok) begin
      r_regs[iWAddr] <= iWData;
    end
  end

  assign oRData1 = (iRAddr1 == {REG_IDX_W{1'b0}}) ? {WIDTH{1'b0}} : r_regs[iRAddr1];
  assign oRData2 = (iRAddr2 == {REG_IDX_W{1'b0}}) ? {WIDTH{1'b0}} : r_regs[iRAddr2];

endmodule

// File: rtl/alu_decode.sv
// RV32 R/I-type decoder with operand fetch and a one-entry output register.
// Optional macro DECODE_BYPASS_EN forwards same-cycle write-back data to source operands.
module alu_decode
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         iClk,
  input  logic         iRstN,
  alu_decode_if.slave  bus
);

  logic                 w_instr_ready;
  logic                 w_accept;
  logic [REG_IDX_W-1:0] w_rs1_idx;
  logic [REG_IDX_W-1:0] w_rs2_idx;
  logic [WIDTH-1:0]     w_rf_rs1;
  logic [WIDTH-1:0]     w_rf_rs2;
  logic [WIDTH-1:0]     w_op1;
  logic [WIDTH-1:0]     w_op2;
  op_class_e            w_cls;
  logic [WIDTH-1:0]     w_nxt_rs1;
  logic [WIDTH-1:0]     w_nxt_rs2;
  logic [11:0]          w_nxt_imm;
  logic                 w_nxt_illegal;

  logic                 r_valid;
  logic                 r_illegal;
  logic [WIDTH-1:0]     r_rs1;
  logic [WIDTH-1:0]     r_rs2;
  logic [11:0]          r_imm;
  logic [4:0]           r_shamt;
  logic [4:0]           r_rd;
  logic [6:0]           r_opcode;
  logic [2:0]           r_funct3;
  logic [6:0]           r_funct7;

  assign w_instr_ready = !r_valid || bus.iReady;
  assign w_accept      = bus.iInstrValid && w_instr_ready;
  assign w_rs1_idx     = bus.iInstr[19:15];
  assign w_rs2_idx     = bus.iInstr[24:20];

  alu_regfile #(.WIDTH(WIDTH)) u_regfile (
    .iClk    (iClk),
    .iRstN   (iRstN),
    .iWe     (bus.iWbEn),
    .iWAddr  (bus.iWbAddr),
    .iWData  (bus.iWbData),
    .iRAddr1 (w_rs1_idx),
    .iRAddr2 (w_rs2_idx),
    .oRData1 (w_rf_rs1),
    .oRData2 (w_rf_rs2)
  );

`ifdef DECODE_BYPASS_EN
  logic w_wb_live;
  assign w_wb_live = bus.iWbEn && (bus.iWbAddr != {REG_IDX_W{1'b0}});
  assign w_op1 = (w_wb_live && (bus.iWbAddr == w_rs1_idx)) ? bus.iWbData : w_rf_rs1;
  assign w_op2 = (w_wb_live && (bus.iWbAddr == w_rs2_idx)) ? bus.iWbData : w_rf_rs2;
`else
  // Without forwarding, a same-cycle write-back is seen only by later instructions
  assign w_op1 = w_rf_rs1;
  assign w_op2 = w_rf_rs2;
`endif

  assign w_cls = classify(bus.iInstr[6:0]);

  // Operand and immediate selection by instruction class
  always_comb begin
    w_nxt_rs1     = {WIDTH{1'b0}};
    w_nxt_rs2     = {WIDTH{1'b0}};
    w_nxt_imm     = 12'h000;
    w_nxt_illegal = 1'b0;
    case (w_cls)
      CLS_R: begin
        w_nxt_rs1 = w_op1;
        w_nxt_rs2 = w_op2;
      end
      CLS_I: begin
        w_nxt_rs1 = w_op1;
        w_nxt_imm = bus.iInstr[31:20];
      end
      default: begin
        w_nxt_illegal = 1'b1;
      end
    endcase
  end

  // One-entry output register: load on acceptance, drop when consumed, hold while stalled
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_rs1     <= {WIDTH{1'b0}};
      r_rs2     <= {WIDTH{1'b0}};
      r_imm     <= 12'h000;
      r_shamt   <= 5'd0;
      r_rd      <= 5'd0;
      r_opcode  <= 7'd0;
      r_funct3  <= 3'd0;
      r_funct7  <= 7'd0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_illegal <= w_nxt_illegal;
      r_rs1     <= w_nxt_rs1;
      r_rs2     <= w_nxt_rs2;
      r_imm     <= w_nxt_imm;
      r_shamt   <= bus.iInstr[24:20];
      r_rd      <= bus.iInstr[11:7];
      r_opcode  <= bus.iInstr[6:0];
      r_funct3  <= bus.iInstr[14:12];
      r_funct7  <= bus.iInstr[31:25];
    end else if (bus.iReady) begin
      r_valid   <= 1'b0;
    end
  end

  assign bus.oInstrReady = w_instr_ready;
  assign bus.oValid      = r_valid;
  assign bus.oIllegal    = r_illegal;
  assign bus.oRS1        = $signed(r_rs1);
  assign bus.oRS2        = $signed(r_rs2);
  assign bus.oImm        = r_imm;
  assign bus.oShamt      = r_shamt;
  assign bus.oRdAddr     = r_rd;
  assign bus.oOpcode     = r_opcode;
  assign bus.oFunct3     = r_funct3;
  assign bus.oFunct7     = r_funct7;

endmodule
